// File: rtl/lapido_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lapido_pkg - fetch FSM states and opcode constants shared with control.
// Rev 1.0
// ----------------------------------------------------------------------------
package lapido_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SQUASH = 2'd3
  } fetch_state_t;

  // All-zero word decodes as NOP (type bits [31:29] = 000) in control.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ALU   = 3'b001;
  localparam logic [2:0] OP_CONST = 3'b010;
  localparam logic [2:0] OP_MEM   = 3'b100;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit_if - instruction memory req/ack read channel.
// Rev 1.0
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  imemReq;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic                  imemAck;
  logic [31:0]           imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemData
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit - PC owner, imem req/ack fetch FSM and instruction register.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_unit
  import lapido_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  wire                   clock,
  input  wire                   reset_n,
  input  wire                   stall,
  input  wire                   branchTaken,
  input  wire  [ADDR_WIDTH-1:0] branchTarget,
  fetch_unit_if.master          imem,
  output logic [31:0]           instruction,
  output logic                  instrValid,
  output logic [ADDR_WIDTH-1:0] pcOut
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] req_addr_nxt;
  logic                  req;
  logic                  req_nxt;
  logic [31:0]           ir_nxt;
  logic                  valid_nxt;
  logic [ADDR_WIDTH-1:0] pc_out_nxt;

  logic redirect;
  logic ir_free;
  logic issue;
  logic accept;

  assign redirect = branchTaken && (state != ST_IDLE);
  assign ir_free  = !instrValid || !stall;
  assign issue    = (state == ST_FETCH) && ir_free && !redirect;
  // An ack that cannot be absorbed because the IR is stalled keeps WAIT alive.
  assign accept   = (state == ST_WAIT) && imem.imemAck && ir_free && !redirect;

  assign imem.imemReq  = req;
  assign imem.imemAddr = req_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  if (issue) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem.imemAck && (redirect || ir_free)) begin
          state_nxt = ST_FETCH;
        end else if (redirect) begin
          state_nxt = ST_SQUASH;
        end
      end
      ST_SQUASH: if (imem.imemAck) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_nxt      = (state_nxt == ST_WAIT) || (state_nxt == ST_SQUASH);
    req_addr_nxt = issue ? pc : req_addr;

    pc_nxt = pc;
    if (redirect) begin
      pc_nxt = branchTarget;
    end else if (accept) begin
      pc_nxt = req_addr + PC_ONE;
    end

    ir_nxt     = instruction;
    valid_nxt  = instrValid;
    pc_out_nxt = pcOut;
    if (redirect) begin
      ir_nxt    = NOP_INSTR;
      valid_nxt = 1'b0;
    end else if (accept) begin
      ir_nxt     = imem.imemData;
      valid_nxt  = 1'b1;
      pc_out_nxt = req_addr;
    end else if (!stall) begin
      ir_nxt    = NOP_INSTR;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      req         <= 1'b0;
      instruction <= NOP_INSTR;
      instrValid  <= 1'b0;
      pcOut       <= '0;
    end else begin
      pc          <= pc_nxt;
      req_addr    <= req_addr_nxt;
      req         <= req_nxt;
      instruction <= ir_nxt;
      instrValid  <= valid_nxt;
      pcOut       <= pc_out_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_unit - directed vector table, random stream model, reset sequences.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int              AW     = 16;
  localparam logic [AW-1:0]   RST_PC = 16'h0000;
  localparam logic [31:0]     GARB   = 32'hDEAD_BEEF;

  logic          clock        = 1'b0;
  logic          reset_n      = 1'b0;
  logic          stall        = 1'b0;
  logic          branchTaken  = 1'b0;
  logic [AW-1:0] branchTarget = '0;
  logic [31:0]   instruction;
  logic          instrValid;
  logic [AW-1:0] pcOut;

  fetch_unit_if #(.ADDR_WIDTH(AW)) imem_bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imem         (imem_bus),
    .instruction  (instruction),
    .instrValid   (instrValid),
    .pcOut        (pcOut)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory image: every address holds a distinct, recognisable word.
  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  typedef struct {
    logic          stall;
    logic          br;
    logic [AW-1:0] tgt;
    logic          ack;
    logic [31:0]   data;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [AW-1:0] t,
                              input logic a, input logic [31:0] d, input logic rq,
                              input logic [AW-1:0] ad, input logic v,
                              input logic [31:0] ins, input logic [AW-1:0] pc);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.ack = a; r.data = d;
    r.req = rq; r.addr = ad; r.valid = v; r.instr = ins; r.pc = pc;
    return r;
  endfunction

  vec_t tbl[23];

  logic          p_stall, p_br, p_ack, p_req, p_valid;
  logic [AW-1:0] p_tgt, p_addr, p_pc, mpc;
  logic [31:0]   p_instr;
  bit            stale;
  int            wl, deliveries, dly;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_bus.imemAck  = 1'b0;
    imem_bus.imemData = '0;

    //          stall br tgt       ack data          | req addr      v  instr          pcOut
    tbl[0]  = mk(0, 0, 16'h0000, 0, 32'h0,          0, 16'h0000, 0, 32'h0,          16'h0000);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 32'h0,          1, 16'h0000, 0, 32'h0,          16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 1, memf(16'h0),    0, 16'h0000, 1, memf(16'h0),    16'h0000);
    tbl[3]  = mk(0, 0, 16'h0000, 0, GARB,           1, 16'h0001, 0, 32'h0,          16'h0000);
    tbl[4]  = mk(0, 0, 16'h0000, 1, 32'h2000_0000,  0, 16'h0001, 1, 32'h2000_0000,  16'h0001);
    for (int i = 5; i < 10; i++)
      tbl[i] = mk(1, 0, 16'h0000, 0, GARB,          0, 16'h0001, 1, 32'h2000_0000,  16'h0001);
    tbl[10] = mk(0, 0, 16'h0000, 0, GARB,           1, 16'h0002, 0, 32'h0,          16'h0000);
    tbl[11] = mk(0, 0, 16'h0000, 0, GARB,           1, 16'h0002, 0, 32'h0,          16'h0000);
    tbl[12] = mk(0, 1, 16'h0040, 0, GARB,           1, 16'h0002, 0, 32'h0,          16'h0000);
    tbl[13] = mk(0, 0, 16'h0000, 1, memf(16'h2),    0, 16'h0002, 0, 32'h0,          16'h0000);
    tbl[14] = mk(0, 0, 16'h0000, 0, GARB,           1, 16'h0040, 0, 32'h0,          16'h0000);
    tbl[15] = mk(0, 0, 16'h0000, 1, memf(16'h40),   0, 16'h0040, 1, memf(16'h40),   16'h0040);
    tbl[16] = mk(0, 1, 16'hFFFF, 0, GARB,           0, 16'h0040, 0, 32'h0,          16'h0000);
    tbl[17] = mk(0, 0, 16'h0000, 0, GARB,           1, 16'hFFFF, 0, 32'h0,          16'h0000);
    tbl[18] = mk(0, 0, 16'h0000, 1, memf(16'hFFFF), 0, 16'hFFFF, 1, memf(16'hFFFF), 16'hFFFF);
    tbl[19] = mk(0, 0, 16'h0000, 0, GARB,           1, 16'h0000, 0, 32'h0,          16'h0000);
    tbl[20] = mk(0, 1, 16'h0123, 1, memf(16'h0),    0, 16'h0000, 0, 32'h0,          16'h0000);
    tbl[21] = mk(0, 0, 16'h0000, 0, GARB,           1, 16'h0123, 0, 32'h0,          16'h0000);
    tbl[22] = mk(0, 0, 16'h0000, 1, memf(16'h123),  0, 16'h0123, 1, memf(16'h123),  16'h0123);

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_req",   {31'b0, imem_bus.imemReq}, 32'h0);
    chk("reset_addr",  {16'b0, imem_bus.imemAddr}, {16'b0, RST_PC});
    chk("reset_valid", {31'b0, instrValid}, 32'h0);
    chk("reset_instr", instruction, 32'h0);
    chk("reset_pcout", {16'b0, pcOut}, 32'h0);

    // Directed vectors: inputs held for one cycle, outputs checked after the edge
    reset_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      stall             = tbl[i].stall;
      branchTaken       = tbl[i].br;
      branchTarget      = tbl[i].tgt;
      imem_bus.imemAck  = tbl[i].ack;
      imem_bus.imemData = tbl[i].data;
      @(negedge clock);
      chk($sformatf("row%0d_req", i),   {31'b0, imem_bus.imemReq}, {31'b0, tbl[i].req});
      chk($sformatf("row%0d_addr", i),  {16'b0, imem_bus.imemAddr}, {16'b0, tbl[i].addr});
      chk($sformatf("row%0d_valid", i), {31'b0, instrValid}, {31'b0, tbl[i].valid});
      chk($sformatf("row%0d_instr", i), instruction, tbl[i].instr);
      if (tbl[i].valid)
        chk($sformatf("row%0d_pcout", i), {16'b0, pcOut}, {16'b0, tbl[i].pc});
    end

    // Random phase against a stream-level model of the fetch rules
    reset_n = 1'b0;
    stall = 0; branchTaken = 0; branchTarget = '0;
    imem_bus.imemAck = 0; imem_bus.imemData = '0;
    @(negedge clock);
    reset_n = 1'b1;
    p_stall = 0; p_br = 0; p_tgt = '0; p_ack = 0;
    p_req = 0; p_addr = RST_PC; p_valid = 0; p_instr = '0; p_pc = '0;
    mpc = RST_PC; stale = 0; wl = -1; deliveries = 0;

    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (k > 0) begin
        if (p_br) begin
          chk("br_clr_valid", {31'b0, instrValid}, 32'h0);
          chk("br_clr_instr", instruction, 32'h0);
        end else if (p_req && p_ack) begin
          if (stale) begin
            chk("squash_valid", {31'b0, instrValid}, 32'h0);
          end else begin
            chk("load_valid", {31'b0, instrValid}, 32'h1);
            chk("load_instr", instruction, memf(p_addr));
            chk("load_pcout", {16'b0, pcOut}, {16'b0, p_addr});
            deliveries++;
          end
        end else if (p_valid && p_stall) begin
          chk("stall_valid", {31'b0, instrValid}, 32'h1);
          chk("stall_instr", instruction, p_instr);
          chk("stall_pcout", {16'b0, pcOut}, {16'b0, p_pc});
        end else begin
          chk("consume_valid", {31'b0, instrValid}, 32'h0);
          chk("consume_instr", instruction, 32'h0);
        end

        if (p_req && !p_ack) begin
          chk("req_hold", {31'b0, imem_bus.imemReq}, 32'h1);
          chk("addr_hold", {16'b0, imem_bus.imemAddr}, {16'b0, p_addr});
        end else if (p_req) begin
          chk("req_drop", {31'b0, imem_bus.imemReq}, 32'h0);
        end else begin
          chk("issue", {31'b0, imem_bus.imemReq}, {31'b0, !p_br && !(p_valid && p_stall)});
          if (imem_bus.imemReq)
            chk("issue_addr", {16'b0, imem_bus.imemAddr}, {16'b0, mpc});
        end

        if (p_br) mpc = p_tgt;
        else if (p_req && p_ack && !stale) mpc = p_addr + 16'd1;
        if (p_req && p_ack) stale = 0;
        else if (p_req && p_br) stale = 1;
      end

      stall        = ($urandom % 10) < 3;
      branchTaken  = (k >= 2) && (($urandom % 100) < 6);
      branchTarget = (($urandom % 4) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                           : 16'($urandom);
      dly = (k < 300) ? 3 : int'($urandom_range(0, 3));
      if (imem_bus.imemReq) begin
        if (wl < 0) wl = dly;
        if (wl == 0) begin
          imem_bus.imemAck  = 1'b1;
          imem_bus.imemData = memf(imem_bus.imemAddr);
          wl = -1;
        end else begin
          imem_bus.imemAck  = 1'b0;
          imem_bus.imemData = $urandom;
          wl--;
        end
      end else begin
        imem_bus.imemAck  = 1'b0;
        imem_bus.imemData = $urandom;
        wl = -1;
      end

      p_stall = stall; p_br = branchTaken; p_tgt = branchTarget; p_ack = imem_bus.imemAck;
      p_req = imem_bus.imemReq; p_addr = imem_bus.imemAddr;
      p_valid = instrValid; p_instr = instruction; p_pc = pcOut;
    end
    chk("progress", {31'b0, deliveries > 200}, 32'h1);

    // Asynchronous reset in the middle of an outstanding request
    stall = 0; branchTaken = 0; imem_bus.imemAck = 0;
    for (int i = 0; i < 10 && !imem_bus.imemReq; i++) @(negedge clock);
    chk("pre_rst_req", {31'b0, imem_bus.imemReq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_req",   {31'b0, imem_bus.imemReq}, 32'h0);
    chk("async_rst_addr",  {16'b0, imem_bus.imemAddr}, {16'b0, RST_PC});
    chk("async_rst_valid", {31'b0, instrValid}, 32'h0);
    chk("async_rst_instr", instruction, 32'h0);

    // Load the first word after reset and hold it under stall
    @(negedge clock);
    reset_n = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 10 && !instrValid; i++) begin
      imem_bus.imemAck  = imem_bus.imemReq;
      imem_bus.imemData = memf(imem_bus.imemAddr);
      @(negedge clock);
    end
    imem_bus.imemAck = 1'b0;
    chk("first_valid", {31'b0, instrValid}, 32'h1);
    chk("first_instr", instruction, memf(RST_PC));
    chk("first_pcout", {16'b0, pcOut}, {16'b0, RST_PC});

    // Reset with a valid, stalled IR must clear it immediately
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ir_valid", {31'b0, instrValid}, 32'h0);
    chk("rst_ir_instr", instruction, 32'h0);
    chk("rst_ir_pcout", {16'b0, pcOut}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 10 && !imem_bus.imemReq; i++) @(negedge clock);
    chk("post_rst_req",  {31'b0, imem_bus.imemReq}, 32'h1);
    chk("post_rst_addr", {16'b0, imem_bus.imemAddr}, {16'b0, RST_PC});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
